ins_cache_assoc: RTL



---
 rtl/ins_cache_pkg.sv | 39 +++
 rtl/ins_cache_plru.sv | 75 +++++++
 rtl/ins_cache_assoc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ins_cache_pkg.sv
// Shared FSM state type and derived-width helpers for the instruction cache.
package ins_cache_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_READ = 1'b1
    } state_t;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int num_sets, input int words_per_line);
        return 32 - idx_w(num_sets) - off_w(words_per_line);
    endfunction

    function automatic int line_w(input int words_per_line);
        return 32 * words_per_line;
    endfunction

    function automatic int maddr_w(input int words_per_line);
        return 32 - off_w(words_per_line);
    endfunction

    // way index width; a direct-mapped cache still carries a 1-bit way field
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // tree-PLRU node bits per set (WAYS-1), never narrower than one bit
    function automatic int node_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/ins_cache_plru.sv
// Per-set tree pseudo-LRU storage: reports the replacement way of one set and
// marks a way most recently used in another set.
module ins_cache_plru
    import ins_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int WAYS     = 2,
    localparam int IDX_W   = idx_w(NUM_SETS),
    localparam int WAY_W   = way_w(WAYS),
    localparam int NODE_W  = node_w(WAYS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [IDX_W-1:0] victim_set,
    output logic [WAY_W-1:0] victim,
    input  logic             update_en,
    input  logic [IDX_W-1:0] update_set,
    input  logic [WAY_W-1:0] update_way
);

    // node bit = 0 points at the lower half, 1 at the upper half
    logic [NODE_W-1:0] nodes [NUM_SETS];
    logic [NODE_W-1:0] cur_nodes;
    logic [NODE_W-1:0] next_nodes;

    assign cur_nodes = nodes[victim_set];

    generate
        if (WAYS == 4) begin : g_four
            logic [NODE_W-1:0] upd_nodes;
            assign upd_nodes = nodes[update_set];

            // follow the root, then the chosen half's node
            always_comb begin
                victim = cur_nodes[0] ? {1'b1, cur_nodes[2]} : {1'b0, cur_nodes[1]};
            end

            // point every node on the accessed path away from the accessed way
            always_comb begin
                next_nodes    = upd_nodes;
                next_nodes[0] = ~update_way[1];
                if (update_way[1]) begin
                    next_nodes[2] = ~update_way[0];
                end else begin
                    next_nodes[1] = ~update_way[0];
                end
            end
        end else if (WAYS == 2) begin : g_two
            assign victim     = cur_nodes;
            assign next_nodes = ~update_way;
        end else begin : g_one
            logic unused_one;
            assign unused_one = ^{cur_nodes, update_way};
            assign victim     = '0;
            assign next_nodes = '0;
        end
    endgenerate

    // node storage: cleared by reset and by flush, written on each access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                nodes[s] <= '0;
            end
        end else if (clear) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                nodes[s] <= '0;
            end
        end else if (update_en) begin
            nodes[update_set] <= next_nodes;
        end
    end

endmodule

// File: rtl/ins_cache_assoc.sv
// Set-associative read-only instruction cache with zero-wait hits and a
// blocking line fill from main memory.
//
//   state    | meaning
//   IDLE     | lookup; hits served combinationally, misses latched
//   MEM_READ | line request to memory outstanding for the latched set/way
module ins_cache_assoc
    import ins_cache_pkg::*;
#(
    parameter int NUM_SETS       = 8,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4,
    localparam int OFF_W         = off_w(WORDS_PER_LINE),
    localparam int IDX_W         = idx_w(NUM_SETS),
    localparam int TAG_W         = tag_w(NUM_SETS, WORDS_PER_LINE),
    localparam int LINE_W        = line_w(WORDS_PER_LINE),
    localparam int MADDR_W       = maddr_w(WORDS_PER_LINE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic [31:0]        address,
    input  logic               flush,
    output logic [31:0]        readdata,
    output logic               busywait,
    output logic               mem_read,
    output logic [MADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]  mem_readdata,
    input  logic               mem_busywait
);

    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = way_w(WAYS);

    state_t state, next_state;

    logic [LINE_W-1:0] data_array [WAYS][NUM_SETS];
    logic [TAG_W-1:0]  tag_array  [WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] valid [WAYS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              unused_lsb;

    logic [TAG_W-1:0] lat_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [WAY_W-1:0] lat_way;
    logic             flush_pend;
    logic [31:0]      last_data;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [31:0]      hit_word;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] plru_victim;

    logic hit_access;
    logic miss_start;
    logic fill_done;
    logic do_clear;

    assign req_tag    = address[31:IDX_W+OFF_W];
    assign req_idx    = address[IDX_W+OFF_W-1:OFF_W];
    assign req_word   = address[OFF_W-1:2];
    assign unused_lsb = ^address[1:0];

    // tag compare across the indexed set; first matching valid way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[w][req_idx] && (tag_array[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // select the requested word out of the hitting line
    always_comb begin
        logic [LINE_W-1:0] line;
        line     = data_array[hit_way][req_idx];
        hit_word = line[31:0];
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (req_word == WORD_W'(k)) begin
                hit_word = line[k*32 +: 32];
            end
        end
    end

    // an empty way is always preferred over evicting a live line
    always_comb begin
        logic found;
        found      = 1'b0;
        victim_way = plru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w][req_idx]) begin
                found      = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
    end

    ins_cache_plru #(
        .NUM_SETS (NUM_SETS),
        .WAYS     (WAYS)
    ) u_plru (
        .clock      (clock),
        .reset      (reset),
        .clear      (do_clear),
        .victim_set (req_idx),
        .victim     (plru_victim),
        .update_en  (hit_access | (fill_done & ~do_clear)),
        .update_set (hit_access ? req_idx : lat_idx),
        .update_way (hit_access ? hit_way : lat_way)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next state: a flush in IDLE takes priority over starting a fill
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (!flush && read && !hit) next_state = MEM_READ;
            MEM_READ: if (!mem_busywait)          next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // outputs and internal strobes; everything is quiet while reset is held
    always_comb begin
        busywait   = 1'b0;
        mem_read   = 1'b0;
        hit_access = 1'b0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        do_clear   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        busywait = 1'b1;
                        do_clear = 1'b1;
                    end else if (read && hit) begin
                        hit_access = 1'b1;
                    end else if (read) begin
                        busywait   = 1'b1;
                        miss_start = 1'b1;
                    end
                end
                MEM_READ: begin
                    busywait = 1'b1;
                    mem_read = 1'b1;
                    if (!mem_busywait) begin
                        fill_done = 1'b1;
                        do_clear  = flush_pend | flush;
                    end
                end
                default: ;
            endcase
        end
    end

    assign readdata    = hit_access ? hit_word : last_data;
    assign mem_address = {lat_tag, lat_idx};

    // miss bookkeeping, pending flush and the held read data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_way    <= '0;
            flush_pend <= 1'b0;
            last_data  <= '0;
        end else begin
            if (miss_start) begin
                lat_tag <= req_tag;
                lat_idx <= req_idx;
                lat_way <= victim_way;
            end
            if (fill_done) begin
                flush_pend <= 1'b0;
            end else if ((state == MEM_READ) && flush) begin
                flush_pend <= 1'b1;
            end
            if (hit_access) begin
                last_data <= hit_word;
            end
        end
    end

    // valid bits: flush clears everything, including a line filled in the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
            end
        end else if (do_clear) begin
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
            end
        end else if (fill_done) begin
            valid[lat_way][lat_idx] <= 1'b1;
        end
    end

    // data and tag arrays are masked by valid and need no reset
    always_ff @(posedge clock) begin
        if (fill_done) begin
            data_array[lat_way][lat_idx] <= mem_readdata;
            tag_array[lat_way][lat_idx]  <= lat_tag;
        end
    end

endmodule
